// File: rtl/riscv_pkg.sv
// Shared arbiter constants: FSM state encodings and requester IDs.
package riscv_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t RESP  = 2'd2;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    // Bit position in a grant vector equals the requester ID.
    function automatic logic [1:0] req_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Two-requester grant selection; MEM_ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise load/store has fixed priority over fetch.
module mem_arb_grant
    import riscv_pkg::*;
(
    input  logic       if_valid,
    input  logic       ls_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic       last_grant,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (if_valid && ls_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant = req_onehot((last_grant == REQ_IF) ? REQ_LS : REQ_IF);
`else
            grant = req_onehot(REQ_LS);
`endif
        end else if (if_valid) begin
            grant = req_onehot(REQ_IF);
        end else if (ls_valid) begin
            grant = req_onehot(REQ_LS);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin grants (default: LS priority).
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         if_req_valid,
    output logic                         if_req_ready,
    input  logic [ADDR_W-1:0]            if_addr,
    output logic                         if_rsp_valid,
    output logic [31:0]                  if_rsp_data,
    input  logic                         ls_req_valid,
    output logic                         ls_req_ready,
    input  logic [ADDR_W-1:0]            ls_addr,
    input  logic                         ls_we,
    input  logic [3:0]                   ls_wstrb,
    input  logic [31:0]                  ls_wdata,
    output logic                         ls_rsp_valid,
    output logic [31:0]                  ls_rsp_data,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [3:0]                   mem_wstrb,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    state_t        state_q, state_d;
    logic          cmd_id_q;
    logic          cmd_we_q;
    logic [3:0]    cmd_wstrb_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   if_data_q;
    logic [31:0]   ls_data_q;
    logic [1:0]    grant;
    logic          accept;
    logic          sel_ls;
    logic          in_resp;
    logic [31:0]   rsp_word;

    // Byte offset and out-of-range upper address bits are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^{if_addr, ls_addr};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    mem_arb_grant u_grant (
        .if_valid   (if_req_valid),
        .ls_valid   (ls_req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_IF;
        end else if (accept) begin
            last_grant_q <= sel_ls ? REQ_LS : REQ_IF;
        end
    end
`else
    mem_arb_grant u_grant (
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .grant    (grant)
    );
`endif

    assign accept  = (state_q == IDLE) && (if_req_valid || ls_req_valid);
    assign sel_ls  = grant[REQ_LS];
    assign in_resp = (state_q == RESP);

    // Ready is gated by rst_n so it drops immediately when reset asserts.
    assign if_req_ready = rst_n && (state_q == IDLE) && grant[REQ_IF];
    assign ls_req_ready = rst_n && (state_q == IDLE) && grant[REQ_LS];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_id_q    <= REQ_IF;
            cmd_we_q    <= 1'b0;
            cmd_wstrb_q <= 4'b0000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            if_data_q   <= 32'h0;
            ls_data_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_id_q    <= sel_ls ? REQ_LS : REQ_IF;
                cmd_we_q    <= sel_ls && ls_we;
                cmd_wstrb_q <= sel_ls ? ls_wstrb : 4'b0000;
                addr_q      <= sel_ls ? ls_addr[2 +: AW] : if_addr[2 +: AW];
                // Fetches leave mem_wdata at its last value.
                if (sel_ls) begin
                    wdata_q <= ls_wdata;
                end
            end
            if (in_resp) begin
                if (cmd_id_q == REQ_LS) begin
                    ls_data_q <= rsp_word;
                end else begin
                    if_data_q <= rsp_word;
                end
            end
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en && cmd_we_q;
    assign mem_wstrb = mem_en ? cmd_wstrb_q : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign rsp_word     = cmd_we_q ? 32'h0 : mem_rdata;
    assign if_rsp_valid = in_resp && (cmd_id_q == REQ_IF);
    assign ls_rsp_valid = in_resp && (cmd_id_q == REQ_LS);
    assign if_rsp_data  = if_rsp_valid ? rsp_word : if_data_q;
    assign ls_rsp_data  = ls_rsp_valid ? rsp_word : ls_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 1-cycle memory.
// Expected arbitration order follows MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid, ls_req_ready;
    logic [31:0] ls_addr;
    logic        ls_we;
    logic [3:0]  ls_wstrb;
    logic [31:0] ls_wdata;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        mem_en, mem_we;
    logic [3:0]  mem_wstrb;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int passed = 0;
    int total  = 0;
    logic exp_ls;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    mem_arbiter #(
        .MEM_WORDS (1024),
        .ADDR_W    (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .ls_req_valid (ls_req_valid),
        .ls_req_ready (ls_req_ready),
        .ls_addr      (ls_addr),
        .ls_we        (ls_we),
        .ls_wstrb     (ls_wstrb),
        .ls_wdata     (ls_wdata),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_data  (ls_rsp_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Memory image is reloaded on every clock while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= 32'h1111_1111;
            mem[4] <= 32'hDEAD_BEEF;
            mem[8] <= 32'h1234_5678;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we && mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        if_req_valid = 1'b1; if_addr = 32'h10;
        ls_req_valid = 1'b0; ls_addr = 32'h0; ls_we = 1'b0; ls_wstrb = 4'h0; ls_wdata = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_if_ready", if_req_ready, 0);
        check("rst_ls_ready", ls_req_ready, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
        check("rst_if_data", if_rsp_data, 0);
        check("rst_ls_data", ls_rsp_data, 0);

        // Fetch-only read of word 4
        rst_n = 1'b1;
        #1 check("f_if_ready", if_req_ready, 1);
        check("f_ls_ready", ls_req_ready, 0);
        @(negedge clk);
        if_req_valid = 1'b0;
        check("f_mem_en", mem_en, 1);
        check("f_mem_addr", mem_addr, 4);
        check("f_mem_we", mem_we, 0);
        check("f_mem_wstrb", mem_wstrb, 0);
        check("f_ready_issue", if_req_ready, 0);
        @(negedge clk);
        check("f_rsp_valid", if_rsp_valid, 1);
        check("f_rsp_data", if_rsp_data, 32'hDEAD_BEEF);
        check("f_ls_rsp", ls_rsp_valid, 0);
        check("f_mem_en_resp", mem_en, 0);
        @(negedge clk);
        check("f_rsp_end", if_rsp_valid, 0);
        check("f_rsp_hold", if_rsp_data, 32'hDEAD_BEEF);

        // Load/store partial write to word 8
        ls_req_valid = 1'b1; ls_we = 1'b1; ls_addr = 32'h22; ls_wstrb = 4'b1100;
        ls_wdata = 32'hAABB_0000;
        #1 check("w_ls_ready", ls_req_ready, 1);
        @(negedge clk);
        ls_req_valid = 1'b0; ls_we = 1'b0; ls_wstrb = 4'h0;
        check("w_mem_en", mem_en, 1);
        check("w_mem_we", mem_we, 1);
        check("w_mem_addr", mem_addr, 8);
        check("w_mem_wstrb", mem_wstrb, 4'b1100);
        check("w_mem_wdata", mem_wdata, 32'hAABB_0000);
        @(negedge clk);
        check("w_rsp_valid", ls_rsp_valid, 1);
        check("w_rsp_data", ls_rsp_data, 0);
        check("w_if_rsp", if_rsp_valid, 0);
        check("w_if_hold", if_rsp_data, 32'hDEAD_BEEF);
        @(negedge clk);
        check("w_idle_we", mem_we, 0);
        check("w_idle_wstrb", mem_wstrb, 0);
        check("w_idle_addr", mem_addr, 8);
        check("w_idle_wdata", mem_wdata, 32'hAABB_0000);
        check("w_mem_model", mem[8], 32'hAABB_5678);

        // Load read with valid dropped after accept
        ls_req_valid = 1'b1; ls_addr = 32'h20;
        #1 check("r_ls_ready", ls_req_ready, 1);
        @(negedge clk);
        ls_req_valid = 1'b0;
        check("r_mem_en", mem_en, 1);
        check("r_mem_we", mem_we, 0);
        check("r_mem_addr", mem_addr, 8);
        @(negedge clk);
        check("r_rsp_valid", ls_rsp_valid, 1);
        check("r_rsp_data", ls_rsp_data, 32'hAABB_5678);
        @(negedge clk);

        // Address wrap: byte 0x1000 maps to word 0
        if_req_valid = 1'b1; if_addr = 32'h1000;
        @(negedge clk);
        if_req_valid = 1'b0;
        check("wrap_mem_en", mem_en, 1);
        check("wrap_mem_addr", mem_addr, 0);
        @(negedge clk);
        check("wrap_rsp_valid", if_rsp_valid, 1);
        check("wrap_rsp_data", if_rsp_data, 32'h1111_1111);
        @(negedge clk);

        // Reset asserted during ISSUE
        if_req_valid = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        if_req_valid = 1'b0;
        check("rs_mem_en_before", mem_en, 1);
        rst_n = 1'b0;
        #1 check("rs_mem_en_async", mem_en, 0);
        check("rs_mem_addr", mem_addr, 0);
        @(negedge clk);
        check("rs_no_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
        check("rs_if_data", if_rsp_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_no_rsp_after", {if_rsp_valid, ls_rsp_valid}, 0);
        check("rs_idle_mem_en", mem_en, 0);

        // Both requesters held for four transactions
        if_req_valid = 1'b1; if_addr = 32'h10;
        ls_req_valid = 1'b1; ls_addr = 32'h20; ls_we = 1'b0;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_ls = (t % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            #1 check("arb_ls_ready", ls_req_ready, exp_ls);
            check("arb_if_ready", if_req_ready, !exp_ls);
            @(negedge clk);
            check("arb_mem_addr", mem_addr, exp_ls ? 32'd8 : 32'd4);
            check("arb_ready_busy", {if_req_ready, ls_req_ready}, 0);
            @(negedge clk);
            check("arb_ls_rsp", ls_rsp_valid, exp_ls);
            check("arb_if_rsp", if_rsp_valid, !exp_ls);
            check("arb_data", exp_ls ? ls_rsp_data : if_rsp_data,
                  exp_ls ? 32'h1234_5678 : 32'hDEAD_BEEF);
            check("arb_ready_resp", {if_req_ready, ls_req_ready}, 0);
            @(negedge clk);
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        #1 check("end_ready", {if_req_ready, ls_req_ready}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
